// File: rtl/jalu_seq.sv
// Sequencer for an external combinational ALU: collects one or two operand beats,
// runs a single EXEC cycle and latches the result into an accumulator and flags.
module jalu_seq (
  input  logic       wclk,
  input  logic       wrst_n,
  input  logic       wstart,
  input  logic [0:2] bop,
  input  logic       wuse_c,
  input  logic       winc,
  input  logic [0:7] bdata,
  input  logic       wvalid,
  output logic       wready,
  output logic [0:7] balu_a,
  output logic [0:7] balu_b,
  output logic [0:2] balu_op,
  output logic       wbus1,
  output logic       wci,
  input  logic [0:7] balu_c,
  input  logic       walu_co,
  input  logic       walu_eq,
  input  logic       walu_al,
  input  logic       walu_z,
  output logic [0:7] bacc,
  output logic [0:3] bflags,
  output logic       wbusy,
  output logic       wdone
);

  typedef enum logic [2:0] {StIdle, StGetA, StGetB, StExec, StDone} state_e;

  localparam logic [0:2] OpAdd = 3'b000;
  localparam logic [0:2] OpShr = 3'b001;
  localparam logic [0:2] OpShl = 3'b010;
  localparam logic [0:2] OpNot = 3'b011;
  localparam logic [0:2] OpCmp = 3'b111;

  state_e     state_q, state_d;
  logic [0:2] op_q, op_d;
  logic       use_c_q, use_c_d;
  logic       inc_q, inc_d;
  logic [0:7] a_q, a_d;
  logic [0:7] b_q, b_d;
  logic [0:7] alu_a_q, alu_a_d;
  logic [0:7] alu_b_q, alu_b_d;
  logic [0:7] acc_q, acc_d;
  logic [0:3] flags_q, flags_d;
  logic       unary;
  logic       exec;

  assign unary = (op_q == OpShr) || (op_q == OpShl) || (op_q == OpNot);
  assign exec  = (state_q == StExec);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    use_c_d = use_c_q;
    inc_d   = inc_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (wstart) begin
          op_d    = bop;
          use_c_d = wuse_c;
          inc_d   = winc;
          state_d = StGetA;
        end
      end
      StGetA: begin
        if (wvalid) begin
          a_d = bdata;
          if (unary || inc_q) begin
            // B is skipped and reads as zero; with inc the ALU forces 0x01 via bus1
            b_d     = '0;
            alu_a_d = bdata;
            alu_b_d = '0;
            state_d = StExec;
          end else begin
            state_d = StGetB;
          end
        end
      end
      StGetB: begin
        if (wvalid) begin
          b_d     = bdata;
          alu_a_d = a_q;
          alu_b_d = bdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_q != OpCmp) acc_d = balu_c;
        flags_d[0] = ((op_q == OpAdd) || (op_q == OpShr) || (op_q == OpShl)) ? walu_co : 1'b0;
        flags_d[1] = walu_al;
        flags_d[2] = walu_eq;
        flags_d[3] = walu_z;
        state_d    = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      use_c_q <= 1'b0;
      inc_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      use_c_q <= use_c_d;
      inc_q   <= inc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign wready  = (state_q == StGetA) || (state_q == StGetB);
  assign balu_a  = alu_a_q;
  assign balu_b  = alu_b_q;
  assign balu_op = exec ? op_q : 3'b000;
  assign wbus1   = exec & inc_q;
  // Carry-in comes from the flag as it stood before this EXEC updates it
  assign wci     = exec & use_c_q & flags_q[0];
  assign bacc    = acc_q;
  assign bflags  = flags_q;
  assign wbusy   = (state_q != StIdle);
  assign wdone   = (state_q == StDone);

endmodule

// File: tb/tb_jalu_seq.sv
// Scoreboard bench for jalu_seq with a behavioural ALU model on the ALU ports.
module tb_jalu_seq;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       wstart = 1'b0;
  logic [0:2] bop = '0;
  logic       wuse_c = 1'b0;
  logic       winc = 1'b0;
  logic [0:7] bdata = '0;
  logic       wvalid = 1'b0;
  logic       wready;
  logic [0:7] balu_a, balu_b;
  logic [0:2] balu_op;
  logic       wbus1, wci;
  logic [0:7] balu_c;
  logic       walu_co, walu_eq, walu_al, walu_z;
  logic [0:7] bacc;
  logic [0:3] bflags;
  logic       wbusy, wdone;

  jalu_seq dut (
    .wclk(wclk), .wrst_n(wrst_n), .wstart(wstart), .bop(bop), .wuse_c(wuse_c),
    .winc(winc), .bdata(bdata), .wvalid(wvalid), .wready(wready), .balu_a(balu_a),
    .balu_b(balu_b), .balu_op(balu_op), .wbus1(wbus1), .wci(wci), .balu_c(balu_c),
    .walu_co(walu_co), .walu_eq(walu_eq), .walu_al(walu_al), .walu_z(walu_z),
    .bacc(bacc), .bflags(bflags), .wbusy(wbusy), .wdone(wdone)
  );

  always #5 wclk = ~wclk;

  // Behavioural ALU
  logic [7:0] m_a, m_b, m_c;
  logic [8:0] m_sum;
  always_comb begin
    m_a     = balu_a;
    m_b     = wbus1 ? 8'h01 : balu_b;
    m_c     = 8'h00;
    m_sum   = 9'h000;
    walu_co = 1'b0;
    case (balu_op)
      3'b000: begin
        m_sum   = {1'b0, m_a} + {1'b0, m_b} + {8'h00, wci};
        m_c     = m_sum[7:0];
        walu_co = m_sum[8];
      end
      3'b001: begin m_c = m_a >> 1; walu_co = m_a[0]; end
      3'b010: begin m_c = m_a << 1; walu_co = m_a[7]; end
      3'b011: m_c = ~m_a;
      3'b100: m_c = m_a & m_b;
      3'b101: m_c = m_a | m_b;
      3'b110: m_c = m_a ^ m_b;
      default: m_c = m_a - m_b;
    endcase
    balu_c  = m_c;
    walu_eq = (m_a == m_b);
    walu_al = (m_a > m_b);
    walu_z  = (m_c == 8'h00);
  end

  typedef struct {
    logic [7:0] acc;
    logic [3:0] flags;
    int         lat;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: compare every completion against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      if (wdone) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(wdone), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("acc", 32'(bacc), 32'(e.acc));
          check("flags", 32'(bflags), 32'(e.flags));
          check("latency", 32'(cyc - e.start + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic uc, input logic inc,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] e_acc,
                        input logic [3:0] e_flags, input logic e_wci, input logic e_bus1);
    exp_t e;
    int   n;
    bit   bin;
    bin = (op == 3'b000 || op >= 3'b100) && !inc;
    @(negedge wclk);
    wstart = 1'b1; bop = op; wuse_c = uc; winc = inc;
    e.acc = e_acc; e.flags = e_flags; e.lat = bin ? 4 : 3; e.start = cyc + 1;
    exp_q.push_back(e);
    @(negedge wclk);
    wstart = 1'b0; wvalid = 1'b1; bdata = a;
    check("ready_geta", 32'(wready), 32'd1);
    if (bin) begin
      @(negedge wclk);
      check("ready_getb", 32'(wready), 32'd1);
      bdata = b;
    end
    @(negedge wclk);
    wvalid = 1'b0;
    check("exec_op", 32'(balu_op), 32'(op));
    check("exec_wci", 32'(wci), 32'(e_wci));
    check("exec_bus1", 32'(wbus1), 32'(e_bus1));
    check("exec_noready", 32'(wready), 32'd0);
    n = 0;
    while (wbusy && n < 8) begin
      @(negedge wclk);
      n++;
    end
    check("idle_return", 32'(wbusy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge wclk);
    check("rst_acc_flags", 32'({bacc, bflags}), 32'd0);
    check("rst_ctl", 32'({wbusy, wready, wdone, wbus1, wci, balu_op}), 32'd0);
    wrst_n = 1'b1;

    // wvalid in IDLE must not be taken
    @(negedge wclk);
    wvalid = 1'b1; bdata = 8'hEE;
    @(negedge wclk);
    check("idle_noready", 32'(wready), 32'd0);
    wvalid = 1'b0;

    //      op      uc    inc   A      B      acc    CAEZ     wci   bus1
    run_op(3'b000, 1'b0, 1'b0, 8'h05, 8'h03, 8'h08, 4'b0100, 1'b0, 1'b0);
    run_op(3'b000, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 4'b1101, 1'b0, 1'b0);
    run_op(3'b000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 4'b0010, 1'b1, 1'b0);
    run_op(3'b010, 1'b0, 1'b0, 8'h81, 8'h00, 8'h02, 4'b1100, 1'b0, 1'b0);
    run_op(3'b000, 1'b0, 1'b0, 8'h50, 8'h05, 8'h55, 4'b0100, 1'b0, 1'b0);
    run_op(3'b111, 1'b0, 1'b0, 8'h10, 8'h10, 8'h55, 4'b0011, 1'b0, 1'b0);
    run_op(3'b000, 1'b0, 1'b1, 8'h7F, 8'h00, 8'h80, 4'b0100, 1'b0, 1'b1);
    run_op(3'b110, 1'b0, 1'b0, 8'hAA, 8'h0F, 8'hA5, 4'b0100, 1'b0, 1'b0);

    // Abort mid-operation: stall in GETB, ignored wstart, then reset
    @(negedge wclk);
    wstart = 1'b1; bop = 3'b000; wuse_c = 1'b0; winc = 1'b0;
    @(negedge wclk);
    wstart = 1'b0; wvalid = 1'b1; bdata = 8'h11;
    @(negedge wclk);
    wvalid = 1'b0;
    repeat (2) @(negedge wclk);
    wstart = 1'b1;
    @(negedge wclk);
    wstart = 1'b0;
    check("stall_getb", 32'({wbusy, wready}), 32'd3);
    #2 wrst_n = 1'b0;
    #1;
    check("abort_data", 32'({bacc, bflags, balu_a, balu_b}), 32'd0);
    check("abort_ctl", 32'({wbusy, wready, wdone, wbus1, wci, balu_op}), 32'd0);
    repeat (3) @(negedge wclk);
    check("abort_idle", 32'({wbusy, wdone}), 32'd0);
    @(posedge wclk);
    #1 wrst_n = 1'b1;

    run_op(3'b011, 1'b0, 1'b0, 8'h0F, 8'h00, 8'hF0, 4'b0100, 1'b0, 1'b0);

    repeat (3) @(negedge wclk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
